// File: rtl/dgs_blink_multi_if.sv
//------------------------------------------------------------------------------
// Module   : dgs_blink_multi_if
// Purpose  : Bundle of the control inputs and LED outputs of dgs_blink_multi.
// Ports    : enable    - 0 holds the timebase and darkens all LEDs
//            mode      - per channel: 0 = count, 1 = mask
//            code      - channel c uses code[c*CODE_W +: CODE_W]
//            led_out   - registered LED drive, 1 = lit
//            frame_stb - 1-cycle strobe on the first cycle of each frame
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dgs_blink_multi_if #(
  parameter int CHANNELS = 3,
  parameter int CODE_W   = 5
);
  logic                       enable;
  logic [CHANNELS-1:0]        mode;
  logic [CHANNELS*CODE_W-1:0] code;
  logic [CHANNELS-1:0]        led_out;
  logic                       frame_stb;

  // master drives the controls, slave is the blink generator
  modport master (output enable, mode, code, input  led_out, frame_stb);
  modport slave  (input  enable, mode, code, output led_out, frame_stb);
endinterface

`default_nettype wire

// File: rtl/dgs_blink_multi.sv
//------------------------------------------------------------------------------
// Module   : dgs_blink_multi
// Purpose  : Multi-channel diagnostic blink generator. All channels share one
//            slot timebase; each channel shows either N short flashes (count
//            mode) or a bit pattern (mask mode), followed by GAP_SLOTS dark
//            slots. Codes are sampled only at frame start.
// Ports    : clk - clock
//            rst - synchronous reset, active-high
//            bus - dgs_blink_multi_if.slave (enable, mode, code in;
//                  led_out, frame_stb out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dgs_blink_multi #(
  parameter int FREQ_HZ   = 100_000_000,
  parameter int PERIOD_US = 10,
  parameter int PULSE_US  = 1,
  parameter int CHANNELS  = 3,
  parameter int CODE_W    = 5,
  parameter int GAP_SLOTS = 3
) (
  input  wire                 clk,
  input  wire                 rst,
  dgs_blink_multi_if.slave    bus
);

  localparam int SLOT_CLKS   = FREQ_HZ / 1_000_000 * PERIOD_US;
  localparam int PULSE_CLKS  = FREQ_HZ / 1_000_000 * PULSE_US;
  localparam int FRAME_SLOTS = CODE_W + GAP_SLOTS;
  localparam int CYC_W       = $clog2(SLOT_CLKS);
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);
  localparam int CMP_W       = (SLOT_W > CODE_W) ? SLOT_W : CODE_W;

  logic [CYC_W-1:0]           cyc_q,     cyc_d;
  logic [SLOT_W-1:0]          slot_q,    slot_d;
  logic [CHANNELS-1:0]        sh_mode_q, sh_mode_d;
  logic [CHANNELS*CODE_W-1:0] sh_code_q, sh_code_d;
  logic [CHANNELS-1:0]        led_q,     led_d;
  logic                       stb_q,     stb_d;

  logic                       w_fs;
  logic                       w_in_code;
  logic                       w_pulse;
  logic [CHANNELS-1:0]        w_active;

  assign w_fs      = bus.enable && (cyc_q == '0) && (slot_q == '0);
  // gap slots are always dark, whatever the code says
  assign w_in_code = slot_q < SLOT_W'(CODE_W);
  assign w_pulse   = cyc_q < CYC_W'(PULSE_CLKS);

  // Per-channel activity. At frame start the live inputs are used directly so
  // the first slot already reflects the code being captured.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic              w_mode_eff;
    logic [CODE_W-1:0] w_code_eff;
    logic              w_cnt_act;
    logic              w_mask_act;

    assign w_mode_eff = w_fs ? bus.mode[gi] : sh_mode_q[gi];
    assign w_code_eff = w_fs ? bus.code[gi*CODE_W +: CODE_W]
                             : sh_code_q[gi*CODE_W +: CODE_W];
    // k < min(code, CODE_W) is k < code once k < CODE_W is known
    assign w_cnt_act  = CMP_W'(slot_q) < CMP_W'(w_code_eff);
    assign w_mask_act = |(w_code_eff & (CODE_W'(1) << slot_q));
    assign w_active[gi] = w_in_code && (w_mode_eff ? w_mask_act : w_cnt_act);
  end

  always_comb begin
    cyc_d     = cyc_q;
    slot_d    = slot_q;
    sh_mode_d = sh_mode_q;
    sh_code_d = sh_code_q;
    led_d     = '0;
    stb_d     = 1'b0;

    if (!bus.enable) begin
      cyc_d  = '0;
      slot_d = '0;
    end else begin
      if (w_fs) begin
        sh_mode_d = bus.mode;
        sh_code_d = bus.code;
      end
      led_d = w_active & {CHANNELS{w_pulse}};
      stb_d = w_fs;
      if (cyc_q == CYC_W'(SLOT_CLKS - 1)) begin
        cyc_d  = '0;
        slot_d = (slot_q == SLOT_W'(FRAME_SLOTS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      slot_q    <= '0;
      sh_mode_q <= '0;
      sh_code_q <= '0;
      led_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      slot_q    <= slot_d;
      sh_mode_q <= sh_mode_d;
      sh_code_q <= sh_code_d;
      led_q     <= led_d;
      stb_q     <= stb_d;
    end
  end

  assign bus.led_out   = led_q;
  assign bus.frame_stb = stb_q;

endmodule

`default_nettype wire

// File: tb/tb_dgs_blink_multi.sv
//------------------------------------------------------------------------------
// Module   : tb_dgs_blink_multi
// Purpose  : Self-checking bench for dgs_blink_multi. A frame-position model
//            (edge count modulo the frame length) predicts LED_OUT/FRAME_STB.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dgs_blink_multi;

  localparam int FREQ_HZ   = 1_000_000;
  localparam int PERIOD_US = 10;
  localparam int PULSE_US  = 3;
  localparam int CHANNELS  = 3;
  localparam int CODE_W    = 5;
  localparam int GAP_SLOTS = 3;
  localparam int SLOT      = FREQ_HZ / 1_000_000 * PERIOD_US;
  localparam int PULSE     = FREQ_HZ / 1_000_000 * PULSE_US;
  localparam int FRAME     = SLOT * (CODE_W + GAP_SLOTS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dgs_blink_multi_if #(.CHANNELS(CHANNELS), .CODE_W(CODE_W)) bus ();

  dgs_blink_multi #(
    .FREQ_HZ(FREQ_HZ), .PERIOD_US(PERIOD_US), .PULSE_US(PULSE_US),
    .CHANNELS(CHANNELS), .CODE_W(CODE_W), .GAP_SLOTS(GAP_SLOTS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // model state: position in frame (in cycles) and codes latched at frame start
  int                         pos = 0;
  logic [CHANNELS-1:0]        m_mode = '0;
  logic [CHANNELS*CODE_W-1:0] m_code = '0;

  function automatic logic lit(input logic m, input logic [CODE_W-1:0] cd, input int slot);
    int n;
    if (slot >= CODE_W) return 1'b0;
    if (m) return cd[slot];
    n = (int'(cd) > CODE_W) ? CODE_W : int'(cd);
    return slot < n;
  endfunction

  task automatic tick(input int n);
    logic [CHANNELS-1:0] e_led;
    logic                e_stb;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e_led = '0;
      e_stb = 1'b0;
      if (rst) begin
        pos = 0; m_mode = '0; m_code = '0;
      end else if (!bus.enable) begin
        pos = 0;
      end else begin
        if (pos == 0) begin
          m_mode = bus.mode;
          m_code = bus.code;
        end
        for (int c = 0; c < CHANNELS; c++)
          e_led[c] = lit(m_mode[c], m_code[c*CODE_W +: CODE_W], pos / SLOT) && (pos % SLOT < PULSE);
        e_stb = (pos == 0);
        pos = (pos + 1) % FRAME;
      end
      #1;
      n_asserts++;
      assert (bus.led_out === e_led) else begin
        n_fail++;
        $error("FAIL led_out t=%0t observed=%b expected=%b", $time, bus.led_out, e_led);
      end
      n_asserts++;
      assert (bus.frame_stb === e_stb) else begin
        n_fail++;
        $error("FAIL frame_stb t=%0t observed=%b expected=%b", $time, bus.frame_stb, e_stb);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = '0;
    bus.code   = '0;
    #2;

    // 1. reset, then ch0 count 3 over one frame plus the next frame start
    bus.code = {5'd0, 5'd0, 5'd3};
    do_reset();
    tick(FRAME + 5);

    // 2. ch1 mask 10101 over two frames
    bus.mode = 3'b010;
    bus.code = {5'd0, 5'b10101, 5'd0};
    do_reset();
    tick(2 * FRAME);

    // 3. code change mid-frame only takes effect next frame
    bus.mode = '0;
    bus.code = {5'd0, 5'd0, 5'd3};
    do_reset();
    tick(15);
    bus.code = {5'd0, 5'd0, 5'd1};
    tick(FRAME + 10);

    // 4. saturation then zero code
    bus.code = {5'd0, 5'd0, 5'd31};
    do_reset();
    tick(FRAME);
    bus.code = {5'd0, 5'd0, 5'd0};
    tick(FRAME + 2);

    // 5. enable drop at edge 21, return at edge 30; then reset at edge 11
    bus.code = {5'd0, 5'd0, 5'd3};
    do_reset();
    tick(21);
    bus.enable = 1'b0;
    tick(9);
    bus.enable = 1'b1;
    tick(25);
    do_reset();
    tick(11);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(25);

    // 6. all channels at once
    bus.mode = 3'b010;
    bus.code = {5'd0, 5'b00100, 5'd2};
    do_reset();
    tick(2 * FRAME);

    // random codes, modes, enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.mode = 3'($urandom);
        bus.code = 15'($urandom);
      end
      if ($urandom_range(0, 199) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 9) == 0) bus.enable = 1'b1;
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    tick(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
